demo_slave_responder: RTL and testbench

- Slave-end counterpart of the master-side demo driver.
- Sits on a bus slave port and accepts read/write requests (addr, wdata, mode, valid) from the bus slave interface.
- Serves requests from an internal register memory after a programmable wait-state delay, then returns rdata with a one-cycle ready pulse.
- Used in demos and benches as the responding device, in place of a UART-bridged slave.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/slave_regmem.sv | 30 +++
 rtl/demo_slave_responder.sv | 141 ++++++++++++++
 tb/tb_demo_slave_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings and default widths for the demo slave responder.
// Latency: none (declarations only). Backpressure: not applicable.
// Flow control: not applicable.
package bus_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_MEM_ADDR_WIDTH = 5;
  localparam int DEF_WAIT_CYCLES    = 2;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h8000;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/slave_regmem.sv
// Single-port register memory with registered read; drop-in point for a BRAM macro.
// Latency: read data valid one cycle after en with we low. Backpressure: none.
// Contents are deliberately not reset.
module slave_regmem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/demo_slave_responder.sv
// Bus slave that serves read/write requests from a local register memory after WAIT_CYCLES wait states.
// Latency: rsp_ready pulses WAIT_CYCLES+2 cycles after accept. Backpressure: none; requests while busy
// or before req_valid has dropped are ignored. Optional DEMO_SLAVE_ADDR_CHECK_EN adds base-address decode.
module demo_slave_responder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_ready,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef struct packed {
    logic                      mode;
    logic                      bad;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0]     wdata;
  } req_t;

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                armed_q;
  logic                accept;
  logic                addr_bad;
  req_t                req_q;
  logic                resp_d1_q;
  logic                mem_en, mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef DEMO_SLAVE_ADDR_CHECK_EN
  assign addr_bad = req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] != BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign addr_bad = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req_valid && armed_q;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wait_cnt_d = '0;
          state_d    = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        armed_q <= 1'b0;
      end else if (!req_valid) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Request fields are captured once; later req_* activity cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= '{mode:  req_mode,
                 bad:   addr_bad,
                 idx:   req_addr[MEM_ADDR_WIDTH-1:0],
                 wdata: req_wdata};
    end
  end

  // Memory is touched only on the RESP edge, and never on a reset edge.
  assign mem_en = (state_q == RESP) && !rst;
  assign mem_we = (req_q.mode == MODE_WRITE) && !req_q.bad;

  slave_regmem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_regmem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (req_q.idx),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  // One extra stage lets the registered memory read land before the response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_d1_q <= 1'b0;
      rsp_ready <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      resp_d1_q <= (state_q == RESP);
      rsp_ready <= resp_d1_q;
      rsp_err   <= resp_d1_q && req_q.bad;
      if (resp_d1_q) begin
        if (req_q.bad) begin
          rsp_rdata <= '1;
        end else if (req_q.mode == MODE_WRITE) begin
          rsp_rdata <= req_q.wdata;
        end else begin
          rsp_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_demo_slave_responder.sv
// Directed bench for demo_slave_responder: two instances (WAIT_CYCLES 2 and 0) checked every cycle
// against a transaction-level model, plus literal expectations on latency and data.
module tb_demo_slave_responder;
  import bus_pkg::*;

`ifdef DEMO_SLAVE_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_mode  [2];
  logic [15:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic [7:0]  rsp_rdata [2];
  logic        rsp_ready [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  demo_slave_responder #(.WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_mode(req_mode[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_ready(rsp_ready[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  demo_slave_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_mode(req_mode[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_ready(rsp_ready[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit started = 1'b0;

  function automatic int wv(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_bad(logic [15:0] a);
    return CHK_EN && (a[15:5] != 11'h400);
  endfunction

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request, memory effect on the RESP edge,
  // response visible WAIT_CYCLES+2 cycles after the accept edge.
  bit          m_armed [2];
  bit          pend    [2];
  int          p_t     [2];
  bit          p_mode  [2];
  bit          p_bad   [2];
  int          p_idx   [2];
  logic [7:0]  p_wd    [2];
  logic [7:0]  p_val   [2];
  bit          p_vk    [2];
  bit          e_ready [2];
  bit          e_err   [2];
  bit          e_busy  [2];
  bit          e_rk    [2];
  logic [7:0]  e_rdata [2];
  logic [7:0]  mem_m   [2][32];
  bit          mem_k   [2][32];

  task automatic model_step(int i);
    int w;
    w = wv(i);
    e_ready[i] = 1'b0;
    e_err[i]   = 1'b0;
    if (rst[i]) begin
      m_armed[i] = 1'b1;
      pend[i]    = 1'b0;
      e_busy[i]  = 1'b0;
      e_rdata[i] = 8'h00;
      e_rk[i]    = 1'b1;
      return;
    end
    if (pend[i] && cyc == p_t[i] + w + 1) begin
      if (p_bad[i]) begin
        p_val[i] = 8'hFF;
        p_vk[i]  = 1'b1;
      end else if (p_mode[i] == MODE_WRITE) begin
        mem_m[i][p_idx[i]] = p_wd[i];
        mem_k[i][p_idx[i]] = 1'b1;
        p_val[i] = p_wd[i];
        p_vk[i]  = 1'b1;
      end else begin
        p_val[i] = mem_m[i][p_idx[i]];
        p_vk[i]  = mem_k[i][p_idx[i]];
      end
    end
    if (pend[i] && cyc == p_t[i] + w + 2) begin
      e_ready[i] = 1'b1;
      e_err[i]   = p_bad[i];
      e_rdata[i] = p_val[i];
      e_rk[i]    = p_vk[i];
      pend[i]    = 1'b0;
    end
    if (!pend[i] && req_valid[i] && m_armed[i]) begin
      pend[i]    = 1'b1;
      p_t[i]     = cyc;
      p_mode[i]  = req_mode[i];
      p_bad[i]   = addr_bad(req_addr[i]);
      p_idx[i]   = int'(req_addr[i][4:0]);
      p_wd[i]    = req_wdata[i];
      m_armed[i] = 1'b0;
    end else if (!req_valid[i]) begin
      m_armed[i] = 1'b1;
    end
    e_busy[i] = pend[i] && (cyc <= p_t[i] + w);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    started = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("cyc_ready", i, 32'(rsp_ready[i]), 32'(e_ready[i]));
        chk("cyc_err",   i, 32'(rsp_err[i]),   32'(e_err[i]));
        chk("cyc_busy",  i, 32'(busy[i]),      32'(e_busy[i]));
        if (e_rk[i]) chk("cyc_rdata", i, 32'(rsp_rdata[i]), 32'(e_rdata[i]));
      end
    end
  end

  task automatic txn(int i, bit mode, logic [15:0] addr, logic [7:0] wd, int hold,
                     logic [7:0] exp_rd, bit exp_er, string nm);
    int t;
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_mode[i]  = mode;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    t = cyc + 1;
    for (int k = 0; k < hold; k++) @(negedge clk);
    req_valid[i] = 1'b0;
    req_mode[i]  = ~mode;
    req_addr[i]  = ~addr;
    req_wdata[i] = ~wd;
    for (int k = 0; k < 40 && !got; k++) begin
      if (rsp_ready[i]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout inst%0d: got no rsp_ready, expected one within 40 cycles", nm, i);
    end else begin
      chk({nm, "_lat"},   i, 32'(cyc - t), 32'(wv(i) + 2));
      chk({nm, "_rdata"}, i, 32'(rsp_rdata[i]), 32'(exp_rd));
      chk({nm, "_err"},   i, 32'(rsp_err[i]), 32'(exp_er));
    end
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int t4;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_mode[i] = MODE_READ;
      req_addr[i] = 16'h0; req_wdata[i] = 8'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(rsp_ready[i]), 32'd0);
      chk("rst_err",   i, 32'(rsp_err[i]),   32'd0);
      chk("rst_busy",  i, 32'(busy[i]),      32'd0);
      chk("rst_rdata", i, 32'(rsp_rdata[i]), 32'd0);
      rst[i] = 1'b0;
    end

    // 1: write then read, WAIT_CYCLES = 2
    txn(0, MODE_WRITE, 16'h8003, 8'hA5, 1, 8'hA5, 1'b0, "t1_wr");
    txn(0, MODE_READ,  16'h8003, 8'h00, 1, 8'hA5, 1'b0, "t1_rd");

    // 2: valid held for 5 cycles yields one transaction
    txn(0, MODE_WRITE, 16'h8004, 8'h3C, 5, 8'h3C, 1'b0, "t2_wr");
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_ready[0]) pulses++;
    end
    chk("t2_extra_pulses", 0, 32'(pulses), 32'd0);
    txn(0, MODE_READ, 16'h8004, 8'h00, 1, 8'h3C, 1'b0, "t2_rd");

    // 3: WAIT_CYCLES = 0 instance
    txn(1, MODE_WRITE, 16'h8000, 8'h11, 1, 8'h11, 1'b0, "t3_wr");
    txn(1, MODE_READ,  16'h8000, 8'h00, 1, 8'h11, 1'b0, "t3_rd");

    // 6: fill all indices with index ^ 5A, read them back, then index 32 aliases to 0
    for (int k = 0; k < 32; k++)
      txn(0, MODE_WRITE, 16'h8000 + 16'(k), 8'(k) ^ 8'h5A, 1, 8'(k) ^ 8'h5A, 1'b0, "t6_wr");
    for (int k = 0; k < 32; k++)
      txn(0, MODE_READ, 16'h8000 + 16'(k), 8'h00, 1, 8'(k) ^ 8'h5A, 1'b0, "t6_rd");
    txn(0, MODE_READ, 16'h8020, 8'h00, 1, CHK_EN ? 8'hFF : 8'h5A, CHK_EN, "t6_wrap");

    // 4: reset during WAIT of a write aborts it
    @(negedge clk);
    req_valid[0] = 1'b1; req_mode[0] = MODE_WRITE; req_addr[0] = 16'h8001; req_wdata[0] = 8'h77;
    t4 = cyc + 1;
    @(negedge clk);
    chk("t4_in_wait_busy", 0, 32'(busy[0]), 32'd1);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t4_busy_after_rst", 0, 32'(busy[0]), 32'd0);
    chk("t4_rdata_after_rst", 0, 32'(rsp_rdata[0]), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_ready[0]) pulses++;
    end
    chk("t4_no_pulse", 0, 32'(pulses), 32'd0);
    chk("t4_elapsed", 0, 32'(cyc - t4), 32'd9);
    txn(0, MODE_READ, 16'h8001, 8'h00, 1, 8'h5B, 1'b0, "t4_rd");

    // 5: out-of-window address: error with decode, alias to index 1 without
    txn(0, MODE_WRITE, 16'h4001, 8'h55, 1, CHK_EN ? 8'hFF : 8'h55, CHK_EN, "t5_wr");
    txn(0, MODE_READ,  16'h8001, 8'h00, 1, CHK_EN ? 8'h5B : 8'h55, 1'b0, "t5_rd");

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
